// File: rtl/uart_frame_reporter_v1_0_if.sv
// Command, BRAM-read and uart_tx handshake signals of the UART frame reporter.
// The reporter uses the master modport; the surrounding logic uses slave.
interface uart_frame_reporter_v1_0_if #(
    parameter int P_ADDR_W = 7
);
    logic                i_cmd_valid;
    logic [47:0]         i48_cmd;
    logic [P_ADDR_W-1:0] o_bram_add;
    logic [31:0]         i32_bram_data;
    logic [47:0]         o48_tx_data;
    logic                o_tx_valid;
    logic                i_tx_ready;

    modport master (
        input  i_cmd_valid, i48_cmd, i32_bram_data, i_tx_ready,
        output o_bram_add, o48_tx_data, o_tx_valid
    );

    modport slave (
        output i_cmd_valid, i48_cmd, i32_bram_data, i_tx_ready,
        input  o_bram_add, o48_tx_data, o_tx_valid
    );
endinterface

// File: rtl/uart_frame_reporter_v1_0.sv
// Transmit side of the 6-byte UART protocol: answers read/state commands from
// the output BRAM and announces transform completion with a notify frame.
module uart_frame_reporter_v1_0 #(
    parameter int         P_ADDR_W       = 7,
    parameter int         P_NWORDS       = 128,
    parameter int         P_BRAM_LATENCY = 2,
    parameter logic [7:0] P_ST_DATA      = 8'h01,
    parameter logic [7:0] P_ST_STATE     = 8'h10,
    parameter logic [7:0] P_ST_ERR       = 8'hEE
) (
    input  logic clk100mhz,
    input  logic rst,
    input  logic i_fft_done,
    output logic o_busy,
    output logic o_result_ready,
    uart_frame_reporter_v1_0_if.master io_bus
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_LOAD, S_SEND, S_NEXT} state_t;
    typedef enum logic [1:0] {K_DATA, K_ERR, K_STATE, K_NOTIFY} kind_t;

    localparam logic [P_ADDR_W-1:0] L_LAST      = P_ADDR_W'(P_NWORDS - 1);
    localparam logic [8:0]          L_NWORDS9   = 9'(P_NWORDS);
    localparam logic [1:0]          L_WAIT_LAST = 2'(P_BRAM_LATENCY - 2);

    state_t              r_state, w_next_state;
    kind_t               r_kind;
    logic                r_dump;
    logic [P_ADDR_W-1:0] r_addr;
    logic [P_ADDR_W-1:0] r_bram_add;
    logic [7:0]          r_err_add;
    logic [1:0]          r_wait_cnt;
    logic [47:0]         r_tx_data;
    logic                r_tx_valid;
    logic                r_result_ready;
    logic                r_notify_pending;
    logic                r_done_q1, r_done_q2;

    logic [7:0] w_cmd_code, w_cmd_add, w_addr8;
    logic       w_is_read, w_is_dump, w_is_single, w_is_err, w_is_state;
    logic       w_handshake, w_last, w_done_rise;

    assign w_cmd_code  = io_bus.i48_cmd[47:40];
    assign w_cmd_add   = io_bus.i48_cmd[39:32];
    assign w_is_read   = io_bus.i_cmd_valid && (w_cmd_code == 8'h02);
    assign w_is_dump   = w_is_read && (w_cmd_add == 8'hFF);
    assign w_is_single = w_is_read && !w_is_dump && ({1'b0, w_cmd_add} < L_NWORDS9);
    assign w_is_err    = w_is_read && !w_is_dump && !w_is_single;
    assign w_is_state  = io_bus.i_cmd_valid && (w_cmd_code == 8'h10);
    assign w_handshake = r_tx_valid && io_bus.i_tx_ready;
    assign w_last      = (r_addr == L_LAST);
    assign w_done_rise = r_done_q1 && !r_done_q2;
    assign w_addr8     = 8'(r_addr);

    assign io_bus.o_bram_add  = r_bram_add;
    assign io_bus.o48_tx_data = r_tx_data;
    assign io_bus.o_tx_valid  = r_tx_valid;
    assign o_busy             = (r_state != S_IDLE);
    assign o_result_ready     = r_result_ready;

    always_ff @(posedge clk100mhz) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: the default first keeps every path assigned, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_is_dump || w_is_single)
                    w_next_state = S_ADDR;
                else if (w_is_err || w_is_state || r_notify_pending)
                    w_next_state = S_LOAD;
            end
            S_ADDR: w_next_state = (P_BRAM_LATENCY == 1) ? S_LOAD : S_WAIT;
            S_WAIT: if (r_wait_cnt == L_WAIT_LAST) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_SEND;
            S_SEND: if (w_handshake) w_next_state = (r_kind == K_DATA) ? S_NEXT : S_IDLE;
            S_NEXT: w_next_state = (r_dump && !w_last) ? S_ADDR : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            r_kind           <= K_DATA;
            r_dump           <= 1'b0;
            r_addr           <= '0;
            r_bram_add       <= '0;
            r_err_add        <= 8'h00;
            r_wait_cnt       <= 2'd0;
            r_tx_data        <= 48'h0;
            r_tx_valid       <= 1'b0;
            r_result_ready   <= 1'b0;
            r_notify_pending <= 1'b0;
            r_done_q1        <= 1'b0;
            r_done_q2        <= 1'b0;
        end else begin
            r_done_q1 <= i_fft_done;
            r_done_q2 <= r_done_q1;
            case (r_state)
                S_IDLE: begin
                    // Command priority must mirror the next-state decode above.
                    if (w_is_dump) begin
                        r_kind <= K_DATA;
                        r_dump <= 1'b1;
                        r_addr <= '0;
                    end else if (w_is_single) begin
                        r_kind <= K_DATA;
                        r_dump <= 1'b0;
                        r_addr <= w_cmd_add[P_ADDR_W-1:0];
                    end else if (w_is_err) begin
                        r_kind    <= K_ERR;
                        r_err_add <= w_cmd_add;
                    end else if (w_is_state) begin
                        r_kind <= K_STATE;
                    end else if (r_notify_pending) begin
                        r_kind <= K_NOTIFY;
                    end
                end
                S_ADDR: begin
                    r_bram_add <= r_addr;
                    r_wait_cnt <= 2'd0;
                end
                S_WAIT: r_wait_cnt <= r_wait_cnt + 2'd1;
                S_LOAD: begin
                    case (r_kind)
                        K_DATA:  r_tx_data <= {P_ST_DATA, w_addr8, io_bus.i32_bram_data};
                        K_ERR:   r_tx_data <= {P_ST_ERR, r_err_add, 32'h0};
                        K_STATE: r_tx_data <= {P_ST_STATE, 8'h00, 31'b0, r_result_ready};
                        default: begin
                            r_tx_data        <= {P_ST_DATA, 8'hFF, 32'h0};
                            r_notify_pending <= 1'b0;
                        end
                    endcase
                end
                S_SEND: r_tx_valid <= !w_handshake;
                S_NEXT: begin
                    if (r_dump) begin
                        if (w_last) r_result_ready <= 1'b0;
                        else        r_addr <= r_addr + P_ADDR_W'(1);
                    end
                end
                default: ;
            endcase
            // A fresh completion outranks the clear at the end of a dump.
            if (w_done_rise) begin
                r_result_ready   <= 1'b1;
                r_notify_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_frame_reporter_v1_0.sv
// Directed bench for uart_frame_reporter_v1_0: table of single-frame commands
// plus hand sequences for notify, latency, dump stall, and reset mid-dump.
module tb_uart_frame_reporter_v1_0;
    localparam int P_ADDR_W = 7;

    logic clk100mhz = 1'b0;
    logic rst = 1'b1;
    logic i_fft_done = 1'b0;
    logic o_busy, o_result_ready;

    uart_frame_reporter_v1_0_if #(.P_ADDR_W(P_ADDR_W)) bus ();

    uart_frame_reporter_v1_0 #(
        .P_ADDR_W(P_ADDR_W), .P_NWORDS(128), .P_BRAM_LATENCY(2),
        .P_ST_DATA(8'h01), .P_ST_STATE(8'h10), .P_ST_ERR(8'hEE)
    ) dut (
        .clk100mhz     (clk100mhz),
        .rst           (rst),
        .i_fft_done    (i_fft_done),
        .o_busy        (o_busy),
        .o_result_ready(o_result_ready),
        .io_bus        (bus)
    );

    always #5 clk100mhz = ~clk100mhz;

    // BRAM model, latency 2: one register stage after the address flop.
    logic [31:0] r_bram_q;
    always @(posedge clk100mhz) r_bram_q <= 32'hA500_0000 + 32'(bus.o_bram_add);
    assign bus.i32_bram_data = r_bram_q;

    logic [47:0] q_frames[$];
    time         last_hs_time = 0;
    time         t_idle = 0;
    always @(posedge clk100mhz) begin
        if (!rst && bus.o_tx_valid && bus.i_tx_ready) begin
            q_frames.push_back(bus.o48_tx_data);
            last_hs_time = $time;
        end
    end

    int n_pass = 0;
    int n_checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk100mhz);
        #1;
    endtask

    task automatic send_cmd(input logic [47:0] c);
        bus.i48_cmd     = c;
        bus.i_cmd_valid = 1'b1;
        tick();
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic pulse_done();
        i_fft_done = 1'b1;
        tick();
        i_fft_done = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            tick();
            n++;
        end
        t_idle = $time;
        check(name, 64'(o_busy), 64'd0);
    endtask

    task automatic wait_add(input string name, input int a, input int budget);
        int n = 0;
        while (int'(bus.o_bram_add) != a && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(bus.o_bram_add), 64'(a));
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!bus.o_tx_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(bus.o_tx_valid), 64'd1);
    endtask

    task automatic check_dump(input string tag, input int exp_total);
        int bad = 0;
        check({tag, "_count"}, 64'(q_frames.size()), 64'(exp_total));
        for (int i = 0; i < 128; i++) begin
            logic [47:0] e;
            e = {8'h01, 8'(i), 32'hA500_0000 + 32'(i)};
            if (i >= q_frames.size()) bad++;
            else if (q_frames[i] !== e) bad++;
        end
        check({tag, "_words"}, 64'(bad), 64'd0);
    endtask

    typedef struct {
        string       name;
        logic [47:0] cmd;
        bit          has_frame;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f0;
        logic [47:0] act;
        int          bad;

        vecs[0] = '{"rd_addr0",   48'h02_00_0000_0000, 1'b1, 48'h01_00_A500_0000};
        vecs[1] = '{"rd_addr127", 48'h02_7F_0000_0000, 1'b1, 48'h01_7F_A500_007F};
        vecs[2] = '{"rd_addr42",  48'h02_2A_DEAD_BEEF, 1'b1, 48'h01_2A_A500_002A};
        vecs[3] = '{"err_add80",  48'h02_80_0000_0000, 1'b1, 48'hEE_80_0000_0000};
        vecs[4] = '{"err_add90",  48'h02_90_0000_0000, 1'b1, 48'hEE_90_0000_0000};
        vecs[5] = '{"err_addFE",  48'h02_FE_0000_0000, 1'b1, 48'hEE_FE_0000_0000};
        vecs[6] = '{"state_set",  48'h10_00_0000_0000, 1'b1, 48'h10_00_0000_0001};
        vecs[7] = '{"ignored_33", 48'h33_05_0000_0000, 1'b0, 48'h0};

        bus.i_cmd_valid = 1'b0;
        bus.i48_cmd     = 48'h0;
        bus.i_tx_ready  = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
        check("rst_tx_data", 64'(bus.o48_tx_data), 64'd0);
        check("rst_bram_add", 64'(bus.o_bram_add), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_result_ready", 64'(o_result_ready), 64'd0);
        rst = 1'b0;
        tick();

        // Completion pulse produces exactly one notify frame.
        q_frames.delete();
        pulse_done();
        repeat (20) tick();
        check("notify_count", 64'(q_frames.size()), 64'd1);
        act = (q_frames.size() > 0) ? q_frames[0] : 48'hx;
        check("notify_frame", 64'(act), 64'h01FF_0000_0000);
        check("notify_result_ready", 64'(o_result_ready), 64'd1);

        // Single-read latency, edge by edge from the command edge.
        q_frames.delete();
        send_cmd(48'h02_05_0000_0000);
        check("lat_e0_busy", 64'(o_busy), 64'd1);
        tick();
        check("lat_e1_add", 64'(bus.o_bram_add), 64'd5);
        tick();
        check("lat_e2_valid", 64'(bus.o_tx_valid), 64'd0);
        tick();
        check("lat_e3_valid", 64'(bus.o_tx_valid), 64'd0);
        check("lat_e3_data", 64'(bus.o48_tx_data), 64'h01_05_A500_0005);
        tick();
        check("lat_e4_valid", 64'(bus.o_tx_valid), 64'd1);
        tick();
        check("lat_e5_valid", 64'(bus.o_tx_valid), 64'd0);
        wait_idle("lat_idle", 20);
        check("lat_count", 64'(q_frames.size()), 64'd1);

        for (int v = 0; v < 8; v++) begin
            q_frames.delete();
            send_cmd(vecs[v].cmd);
            wait_idle({vecs[v].name, "_idle"}, 50);
            repeat (3) tick();
            check({vecs[v].name, "_count"}, 64'(q_frames.size()), vecs[v].has_frame ? 64'd1 : 64'd0);
            if (vecs[v].has_frame) begin
                act = (q_frames.size() > 0) ? q_frames[0] : 48'hx;
                check({vecs[v].name, "_frame"}, 64'(act), 64'(vecs[v].exp));
            end
        end

        // Full dump with a 20-cycle stall at word 40 and a state command during it.
        q_frames.delete();
        send_cmd(48'h02_FF_0000_0000);
        wait_add("stall_reach40", 40, 1000);
        bus.i_tx_ready = 1'b0;
        wait_valid("stall_valid", 20);
        f0 = bus.o48_tx_data;
        check("stall_frame", 64'(f0), 64'h01_28_A500_0028);
        bad = 0;
        bus.i48_cmd = 48'h10_00_0000_0000;
        for (int i = 0; i < 20; i++) begin
            bus.i_cmd_valid = (i == 5);
            tick();
            if (!bus.o_tx_valid || bus.o48_tx_data !== f0) bad++;
        end
        bus.i_cmd_valid = 1'b0;
        check("stall_stable", 64'(bad), 64'd0);
        bus.i_tx_ready = 1'b1;
        wait_idle("dump_idle", 3000);
        check("dump_busy_fall", 64'(t_idle - last_hs_time), 64'd11);
        repeat (10) tick();
        check_dump("dump", 128);
        check("dump_result_ready", 64'(o_result_ready), 64'd0);

        q_frames.delete();
        send_cmd(48'h10_00_0000_0000);
        wait_idle("state_clr_idle", 50);
        repeat (3) tick();
        act = (q_frames.size() > 0) ? q_frames[0] : 48'hx;
        check("state_clr_frame", 64'(act), 64'h10_00_0000_0000);

        // Reset while word 64 is being offered.
        q_frames.delete();
        send_cmd(48'h02_FF_0000_0000);
        wait_add("rst_reach64", 64, 1000);
        bus.i_tx_ready = 1'b0;
        wait_valid("rst_valid_up", 20);
        rst = 1'b1;
        tick();
        check("midrst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
        check("midrst_tx_data", 64'(bus.o48_tx_data), 64'd0);
        check("midrst_bram_add", 64'(bus.o_bram_add), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_result_ready", 64'(o_result_ready), 64'd0);
        rst = 1'b0;
        bus.i_tx_ready = 1'b1;
        q_frames.delete();
        repeat (10) tick();
        check("midrst_no_resend", 64'(q_frames.size()), 64'd0);

        // Fresh dump from address 0 with a completion during it.
        q_frames.delete();
        send_cmd(48'h02_FF_0000_0000);
        wait_add("redump_reach10", 10, 200);
        pulse_done();
        wait_idle("redump_idle", 3000);
        repeat (15) tick();
        check_dump("redump", 129);
        act = (q_frames.size() > 128) ? q_frames[128] : 48'hx;
        check("redump_notify", 64'(act), 64'h01FF_0000_0000);
        check("redump_result_ready", 64'(o_result_ready), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_reporter_v1_0.md
Name: uart_frame_reporter_v1_0

Overview:
Transmit side of the 6-byte UART command protocol. Decodes read and status commands from the UART receiver and reads the xFFT output BRAM. Builds 48-bit response frames {status, address, data[31:0]} and hands them to uart_tx_v1_0 over a valid/ready handshake. It also sends an unsolicited "data output ready" frame when the transform completes.

Parameters:
P_ADDR_W, 7, BRAM address width
P_NWORDS, 128, number of words returned by a full dump; must be <= 2**P_ADDR_W
P_BRAM_LATENCY, 2, clock cycles from address change to valid i32_bram_data (1..3)
P_ST_DATA, 8'h01, status byte for data and done frames
P_ST_STATE, 8'h10, status byte for state frames
P_ST_ERR, 8'hEE, status byte for error frames

Ports:
clk100mhz  in  1  clock
rst  in  1  synchronous, active-high reset
i_cmd_valid  in  1  one-cycle pulse; frame on i48_cmd is valid
i48_cmd  in  48  {cmd[47:40], add[39:32], data[31:0]} from the UART receiver
i_fft_done  in  1  transform-complete level from the xFFT wrapper
o_bram_add  out  P_ADDR_W  output BRAM read address
i32_bram_data  in  32  output BRAM read data
o48_tx_data  out  48  frame to uart_tx, MSB byte sent first
o_tx_valid  out  1  frame valid
i_tx_ready  in  1  uart_tx can accept a frame
o_busy  out  1  transaction in progress
o_result_ready  out  1  sticky flag: a result is available and has not yet been dumped

Behaviour:
- Reset values: o_tx_valid=0, o48_tx_data=0, o_bram_add=0, o_busy=0, o_result_ready=0, FSM=IDLE, notify_pending=0. A reset mid-transaction aborts immediately. o_tx_valid is low after the first edge with rst=1, and no partial frame is resent afterwards.
- Done detect: i_fft_done is registered once. A rising edge sets o_result_ready=1 and notify_pending=1.
- Commands are sampled only in IDLE. Commands that arrive while o_busy=1 are dropped silently.
  - cmd 8'h02, add=8'hFF: full dump, words 0..P_NWORDS-1.
  - cmd 8'h02, add<P_NWORDS: single word at add[P_ADDR_W-1:0].
  - cmd 8'h02, any other add: one error frame {P_ST_ERR, add, 32'h0}.
  - cmd 8'h10: state frame {P_ST_STATE, 8'h00, 31'b0, o_result_ready}.
  - Any other cmd: ignored; stay in IDLE.
- Priority in IDLE: a valid command wins over notify_pending when both are present in the same cycle. notify_pending is serviced on the next return to IDLE.
- Notify frame: {P_ST_DATA, 8'hFF, 32'h0}. Sending it clears notify_pending.
- FSM states: IDLE -> ADDR -> WAIT -> LOAD -> SEND -> NEXT.
  - ADDR: drive o_bram_add.
  - WAIT: count P_BRAM_LATENCY-1 cycles (skipped when the latency is 1).
  - LOAD: capture {P_ST_DATA, zero-extended address, i32_bram_data} into o48_tx_data.
  - SEND: o_tx_valid=1 until a cycle with o_tx_valid & i_tx_ready. o48_tx_data is held stable the whole time. o_tx_valid drops on the edge after the handshake.
  - NEXT: for a dump, if address==P_NWORDS-1, clear o_result_ready and go to IDLE; otherwise increment the address and go to ADDR. For a single read, go to IDLE.
- Error, state and notify frames skip ADDR/WAIT and go IDLE -> LOAD -> SEND -> IDLE.
- The address counter never wraps past P_NWORDS-1.
- o_busy=1 in every state except IDLE.
- Latency, single read with P_BRAM_LATENCY=2 and i_tx_ready=1: command pulse at edge 0; o_bram_add valid after edge 1; data captured at edge 3; o_tx_valid=1 after edge 4; the handshake completes on edge 5.
- A done rising edge during a dump sets notify_pending. The notify frame is sent after the dump finishes. o_result_ready is still cleared by that dump's completion.
- i_tx_ready held low stalls the FSM indefinitely in SEND with no data change.

Test Plan:
1. Reset, then pulse i_fft_done high, i_tx_ready=1 -> exactly one frame 48'h01FF_0000_0000; o_result_ready=1.
2. BRAM model with word[n]=32'hA5000000+n; cmd 48'h02_05_00000000 -> one frame 48'h01_05_A5000005; o_tx_valid rises exactly 4 edges after the command pulse.
3. cmd 48'h02_FF_0 -> 128 frames, addresses 0..127 in order, data matching the model; o_result_ready=0 at the end; o_busy falls after the last handshake.
4. During the full dump, hold i_tx_ready=0 for 20 cycles at word 40 and send a cmd 8'h10 -> frame stable and valid throughout the stall; the state command is dropped; the dump completes intact.
5. cmd 48'h02_90_0 -> 48'hEE_90_0000_0000; then cmd 8'h10 with the result flag set -> 48'h10_00_0000_0001.
6. Assert rst at word 64 of a dump -> o_tx_valid=0 after the next edge and all outputs at reset values; a fresh cmd 8'h02 with add=8'hFF dumps from address 0.
